// File: rtl/univ_counter.sv
// Universal modulo-MOD up/down counter with synchronous clear, clamped
// parallel load, optional saturation, and a registered bound-event pulse.
module univ_counter #(
    parameter int N   = 4,
    parameter int MOD = 10,
    parameter bit SAT = 1'b0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic         up,
    input  logic         clr,
    input  logic         load,
    input  logic [N-1:0] d,
    output logic [N-1:0] Q,
    output logic         max_tick,
    output logic         min_tick,
    output logic         ovf
);

    localparam logic [N-1:0] MAX_VAL = N'(MOD - 1);
    localparam logic [N-1:0] ZERO    = '0;
    localparam logic [N-1:0] ONE     = N'(1);

    if (MOD < 2 || MOD > (1 << N)) begin : g_bad_mod
        $error("univ_counter: MOD must satisfy 2 <= MOD <= 2**N");
    end

    logic [N-1:0] next_q;
    logic         next_ovf;
    logic         at_top;
    logic         at_bottom;

    assign at_top    = (Q == MAX_VAL);
    assign at_bottom = (Q == ZERO);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        next_q   = Q;
        next_ovf = 1'b0;
        if (clr) begin
            next_q = ZERO;
        end else if (load) begin
            // When MOD == 2**N, MAX_VAL is all ones and the clamp never fires.
            next_q = (d > MAX_VAL) ? MAX_VAL : d;
        end else if (en) begin
            if (up) begin
                if (at_top) begin
                    next_ovf = 1'b1;
                    next_q   = SAT ? MAX_VAL : ZERO;
                end else begin
                    next_q = Q + ONE;
                end
            end else begin
                if (at_bottom) begin
                    next_ovf = 1'b1;
                    next_q   = SAT ? ZERO : MAX_VAL;
                end else begin
                    next_q = Q - ONE;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            Q   <= ZERO;
            ovf <= 1'b0;
        end else begin
            Q   <= next_q;
            ovf <= next_ovf;
        end
    end

    // Q is 0 during reset and MOD >= 2, so these read max=0 / min=1 while reset is held.
    assign max_tick = at_top;
    assign min_tick = at_bottom;

endmodule

// File: tb/tb_univ_counter.sv
// Scoreboard bench for univ_counter: three instances (wrap MOD=10, saturate MOD=10,
// wrap MOD=16) share stimulus and are checked against an arithmetic reference model.
module tb_univ_counter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       en, up, clr, load;
    logic [3:0] d;

    logic [3:0] q_o   [3];
    logic       ovf_o [3];
    logic       max_o [3];
    logic       min_o [3];

    typedef struct {
        int inst;
        int q;
        int ovf;
        int mx;
        int mn;
    } exp_t;

    exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    int mod_p [3] = '{10, 10, 16};
    int sat_p [3] = '{0, 1, 0};
    int m_q   [3];
    int m_ovf [3];

    always #5 clk = ~clk;

    univ_counter #(.N(4), .MOD(10), .SAT(1'b0)) u_wrap10 (
        .clk(clk), .reset_n(reset_n), .en(en), .up(up), .clr(clr), .load(load), .d(d),
        .Q(q_o[0]), .max_tick(max_o[0]), .min_tick(min_o[0]), .ovf(ovf_o[0]));

    univ_counter #(.N(4), .MOD(10), .SAT(1'b1)) u_sat10 (
        .clk(clk), .reset_n(reset_n), .en(en), .up(up), .clr(clr), .load(load), .d(d),
        .Q(q_o[1]), .max_tick(max_o[1]), .min_tick(min_o[1]), .ovf(ovf_o[1]));

    univ_counter #(.N(4), .MOD(16), .SAT(1'b0)) u_wrap16 (
        .clk(clk), .reset_n(reset_n), .en(en), .up(up), .clr(clr), .load(load), .d(d),
        .Q(q_o[2]), .max_tick(max_o[2]), .min_tick(min_o[2]), .ovf(ovf_o[2]));

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    // Reference model: counting is arithmetic modulo MOD; a step that starts at the
    // bound in its direction is a bound event, which saturating counters refuse to take.
    task automatic model_step(input int i, input bit c, input bit l, input bit e,
                              input bit u, input int dv);
        int bound;
        if (c) begin
            m_q[i] = 0; m_ovf[i] = 0;
        end else if (l) begin
            m_q[i] = (dv < mod_p[i]) ? dv : mod_p[i] - 1; m_ovf[i] = 0;
        end else if (e) begin
            bound    = u ? (m_q[i] == mod_p[i] - 1) : (m_q[i] == 0);
            m_ovf[i] = bound;
            if (!(bound && sat_p[i] == 1))
                m_q[i] = (m_q[i] + (u ? 1 : mod_p[i] - 1)) % mod_p[i];
        end else begin
            m_ovf[i] = 0;
        end
    endtask

    // Drive one cycle of inputs at the falling edge and queue what the next rising edge must show.
    task automatic step(input bit c, input bit l, input bit e, input bit u, input int dv);
        @(negedge clk);
        clr = c; load = l; en = e; up = u; d = 4'(dv);
        for (int i = 0; i < 3; i++) begin
            model_step(i, c, l, e, u, dv);
            sb.push_back('{inst: i, q: m_q[i], ovf: m_ovf[i],
                           mx: int'(m_q[i] == mod_p[i] - 1), mn: int'(m_q[i] == 0)});
        end
    endtask

    task automatic check_reset_state(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s.u%0d.q", tag, i), int'(q_o[i]), 0);
            check($sformatf("%s.u%0d.ovf", tag, i), int'(ovf_o[i]), 0);
            check($sformatf("%s.u%0d.max_tick", tag, i), int'(max_o[i]), 0);
            check($sformatf("%s.u%0d.min_tick", tag, i), int'(min_o[i]), 1);
        end
    endtask

    // Monitor: after each rising edge, compare every queued expectation with the outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                check($sformatf("u%0d.q", e.inst), int'(q_o[e.inst]), e.q);
                check($sformatf("u%0d.ovf", e.inst), int'(ovf_o[e.inst]), e.ovf);
                check($sformatf("u%0d.max_tick", e.inst), int'(max_o[e.inst]), e.mx);
                check($sformatf("u%0d.min_tick", e.inst), int'(min_o[e.inst]), e.mn);
            end
        end
    end

    initial begin
        int seen16;
        reset_n = 1'b0;
        en = 1'b0; up = 1'b0; clr = 1'b0; load = 1'b0; d = '0;
        for (int i = 0; i < 3; i++) begin
            m_q[i] = 0; m_ovf[i] = 0;
        end
        #2;
        check_reset_state("por");
        @(negedge clk);
        #2 reset_n = 1'b1;

        // Twelve up-counts from reset: 1..9, wrap to 0 with ovf, then 1, 2.
        for (int k = 0; k < 12; k++) step(0, 0, 1, 1, 0);

        // Load 3 then count down across the lower bound.
        step(0, 1, 0, 0, 3);
        for (int k = 0; k < 5; k++) step(0, 0, 1, 0, 0);

        // Clear beats load and enable; then an out-of-range load clamps.
        step(1, 1, 1, 1, 7);
        step(0, 1, 0, 0, 12);
        step(0, 0, 0, 0, 0);

        // Sit on the top bound for three enabled edges, then reverse with no dead cycle.
        step(0, 1, 0, 0, 9);
        for (int k = 0; k < 3; k++) step(0, 0, 1, 1, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0);

        // Saturating and wrapping behaviour at the lower bound.
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 1, 0, 0);

        // Full-range counter: wrap from 15, then visit every value.
        step(0, 1, 0, 0, 15);
        seen16 = 0;
        for (int k = 0; k < 17; k++) begin
            step(0, 0, 1, 1, 0);
            seen16 |= (1 << m_q[2]);
        end
        check("u2.all_values_visited", seen16, 32'hFFFF);

        // Asynchronous reset mid-count, between clock edges.
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) step(0, 0, 1, 1, 0);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1 check_reset_state("async_rst");
        for (int i = 0; i < 3; i++) begin
            m_q[i] = 0; m_ovf[i] = 0;
        end
        step(0, 0, 0, 0, 0);
        #2 reset_n = 1'b1;
        step(0, 0, 1, 1, 0);
        step(0, 0, 1, 1, 0);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(15) == 0, $urandom_range(7) == 0, $urandom_range(3) != 0,
                 1'($urandom), int'($urandom_range(15)));
        end
        step(0, 0, 0, 0, 0);

        @(posedge clk);
        #3;
        check("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/univ_counter.md
UNIV_COUNTER -- requirements
Module: univ_counter

Interface
REQ-001 Parameter N, default 4, SHALL set the count register width in bits.
REQ-002 Parameter MOD, default 10, SHALL set the count range 0..MOD-1, with legal values 2 <= MOD <= 2^N.
REQ-003 Parameter SAT, default 0, SHALL select the bound mode: 0 = wrap-around, 1 = saturate at the bounds.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-006 en  input  1  SHALL be the count enable; the counter steps only when en=1.
REQ-007 up  input  1  SHALL set the count direction: 1 = increment, 0 = decrement.
REQ-008 clr  input  1  SHALL be a synchronous clear to 0.
REQ-009 load  input  1  SHALL be a synchronous parallel-load strobe.
REQ-010 d  input  N  SHALL be the parallel-load value.
REQ-011 Q  output  N  SHALL be the registered count value.
REQ-012 max_tick  output  1  SHALL be combinational and equal 1 when Q == MOD-1.
REQ-013 min_tick  output  1  SHALL be combinational and equal 1 when Q == 0.
REQ-014 ovf  output  1  SHALL be a registered one-cycle pulse flagging a bound event (wrap, or saturated hold).

Function
REQ-015 At each rising clk edge, the next state SHALL follow this priority: clr > load > en > hold.
REQ-016 With clr=1, Q SHALL become 0 and ovf SHALL become 0, regardless of load, en and up.
REQ-017 With load=1 and clr=0:
- d <= MOD-1: Q SHALL become d.
- d >= MOD: Q SHALL become MOD-1 (clamp).
- ovf SHALL become 0.
REQ-018 With en=1, up=1, Q < MOD-1: Q SHALL become Q+1 and ovf SHALL become 0.
REQ-019 With en=1, up=0, Q > 0: Q SHALL become Q-1 and ovf SHALL become 0.
REQ-020 Upper bound, en=1, up=1, Q == MOD-1:
- SAT=0: Q SHALL become 0.
- SAT=1: Q SHALL hold at MOD-1.
- Either mode: ovf SHALL become 1.
REQ-021 Lower bound, en=1, up=0, Q == 0:
- SAT=0: Q SHALL become MOD-1.
- SAT=1: Q SHALL hold at 0.
- Either mode: ovf SHALL become 1.
REQ-022 With en=0, clr=0, load=0: Q SHALL hold and ovf SHALL become 0.
REQ-023 ovf SHALL be high for exactly one cycle per bound event; consecutive bound events SHALL keep ovf high on each of those cycles.
REQ-024 A change of up SHALL take effect at the next enabled edge, with no dead cycle and no extra step.
REQ-025 When MOD == 2^N, wrap SHALL be the natural modulo-2^N overflow and no clamp on load SHALL be needed.
REQ-026 Q SHALL never hold a value >= MOD after any edge following reset.
REQ-027 All internal arithmetic SHALL be N bits wide, with comparisons against the constant MOD-1; no width truncation warnings.

Reset
REQ-028 On reset_n=0, Q SHALL become 0 and ovf SHALL become 0 immediately, without waiting for clk.
REQ-029 Reset asserted mid-count SHALL abort the sequence; after release, counting SHALL resume from 0 at the first edge with en=1.
REQ-030 While reset_n=0, max_tick SHALL be 0 and min_tick SHALL be 1.

Verification (N=4, MOD=10, SAT=0 unless stated)
REQ-031 Hold en=1, up=1 for 12 edges after reset -> Q = 1..9, 0, 1, 2; ovf high only in the cycle after Q 9->0; max_tick high while Q=9.
REQ-032 Load d=3, then en=1, up=0 for 5 edges -> Q = 3, 2, 1, 0, 9, 8; ovf pulses once after 0->9.
REQ-033 Apply clr=1, load=1, d=7, en=1 in the same cycle -> Q=0, ovf=0; load d=12 -> Q=9 (clamp).
REQ-034 With SAT=1, Q=9, en=1, up=1 for 3 edges -> Q stays 9, ovf=1 on each of the 3 cycles; then up=0 -> Q=8, ovf=0.
REQ-035 Count to Q=6, assert reset_n=0 between clk edges -> Q=0 and ovf=0 before the next edge; release -> Q=1 at the first enabled edge.
REQ-036 N=4, MOD=16 up-count from 15 -> Q=0, ovf=1; all Q values 0..15 reachable.
